// File: rtl/pc_flow_sequencer.sv
// -----------------------------------------------------------------------------
// pc_flow_sequencer
//   Control-flow sequencer that sits between the instruction decoder and the
//   ProgramCounter. Each cycle it turns decoder requests (branch, jump, call,
//   return, stall, halt) into the ProgramCounter's LoadValue/LoadEnable and
//   Offset/OffsetEnable controls. It owns a hardware return-address stack and
//   a three-state fetch FSM (RUN / FLUSH / HALT).
//
//   ProgramCounter contract assumed by this block:
//     reset -> 0; LoadEnable -> LoadValue (beats Offset);
//     OffsetEnable -> PC + Offset; otherwise PC + 1.
//   "Hold PC" is therefore expressed as OffsetEnable=1 with Offset=0.
//
// Parameters
//   STACK_DEPTH  return-address stack entries (>= 1)
//   PC_W         program counter width
//   OFF_W        signed relative-branch offset width
//
// Ports
//   i_clock            system clock, rising edge
//   i_reset            asynchronous, active-high reset
//   i_counter_value    current PC from the ProgramCounter
//   i_stall            hold PC this cycle
//   i_branch_req       taken relative branch (condition already resolved)
//   i_branch_offset    signed branch offset
//   i_jump_req         absolute jump to i_jump_target
//   i_call_req         push return address, jump to i_jump_target
//   i_jump_target      absolute target for jump/call
//   i_return_req       pop return address into PC
//   i_halt_req         enter HALT
//   i_resume           leave HALT
//   o_load_value       to ProgramCounter (0 when o_load_enable=0)
//   o_load_enable      to ProgramCounter
//   o_offset           to ProgramCounter (0 when o_offset_enable=0)
//   o_offset_enable    to ProgramCounter
//   o_fetch            instruction at i_counter_value valid for decode
//   o_stack_overflow   sticky: call made while stack full
//   o_stack_underflow  sticky: return made while stack empty
//   o_state            RUN=0, FLUSH=1, HALT=2
// -----------------------------------------------------------------------------
module pc_flow_sequencer #(
  parameter int STACK_DEPTH = 4,
  parameter int PC_W        = 16,
  parameter int OFF_W       = 9
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [PC_W-1:0]  i_counter_value,
  input  logic             i_stall,
  input  logic             i_branch_req,
  input  logic [OFF_W-1:0] i_branch_offset,
  input  logic             i_jump_req,
  input  logic             i_call_req,
  input  logic [PC_W-1:0]  i_jump_target,
  input  logic             i_return_req,
  input  logic             i_halt_req,
  input  logic             i_resume,
  output logic [PC_W-1:0]  o_load_value,
  output logic             o_load_enable,
  output logic [OFF_W-1:0] o_offset,
  output logic             o_offset_enable,
  output logic             o_fetch,
  output logic             o_stack_overflow,
  output logic             o_stack_underflow,
  output logic [1:0]       o_state
);

  // Stack pointer counts occupied entries, so it needs to reach STACK_DEPTH.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Return-address stack. Read is combinational because the popped address
  // has to reach the ProgramCounter in the same cycle as ReturnReq.
  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic [SP_W-1:0] r_sp;
  logic            r_overflow;
  logic            r_underflow;

  logic             w_stack_empty;
  logic             w_stack_full;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [PC_W-1:0]  w_top;
  logic [PC_W-1:0]  w_ret_addr;

  logic             w_load_enable;
  logic [PC_W-1:0]  w_load_value;
  logic             w_offset_enable;
  logic [OFF_W-1:0] w_offset;
  logic             w_fetch;
  logic             w_push;
  logic             w_pop;
  logic             w_set_overflow;
  logic             w_set_underflow;

  assign w_stack_empty = (r_sp == '0);
  assign w_stack_full  = (r_sp == SP_W'(STACK_DEPTH));
  // Push lands at index r_sp, the top lives at r_sp-1. Both indices are only
  // used when they are in range (push never when full, pop never when empty).
  assign w_wr_idx      = IDX_W'(r_sp);
  assign w_rd_idx      = IDX_W'(r_sp - SP_W'(1));
  assign w_top         = r_stack[w_rd_idx];
  // Return address wraps naturally at the PC width (all-ones -> zero).
  assign w_ret_addr    = i_counter_value + PC_W'(1);

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // RUN priority: halt > stall > return > call > jump > branch > none.
  // A return on an empty stack degrades to PC+1 and does not redirect.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_halt_req) begin
          w_state_next = ST_HALT;
        end else if (i_stall) begin
          w_state_next = ST_RUN;
        end else if (i_return_req) begin
          w_state_next = w_stack_empty ? ST_RUN : ST_FLUSH;
        end else if (i_call_req || i_jump_req || i_branch_req) begin
          w_state_next = ST_FLUSH;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        w_state_next = ST_RUN;
      end
      ST_HALT: begin
        w_state_next = i_resume ? ST_RUN : ST_HALT;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs and stack/flag strobes
  // Everything is forced inactive while reset is high so the ProgramCounter
  // sees no enables during an asynchronous reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_load_enable   = 1'b0;
    w_load_value    = '0;
    w_offset_enable = 1'b0;
    w_offset        = '0;
    w_fetch         = 1'b0;
    w_push          = 1'b0;
    w_pop           = 1'b0;
    w_set_overflow  = 1'b0;
    w_set_underflow = 1'b0;
    if (!i_reset) begin
      case (r_state)
        ST_RUN: begin
          if (i_halt_req || i_stall) begin
            // Hold PC; the instruction at CounterValue is not consumed.
            w_offset_enable = 1'b1;
          end else begin
            w_fetch = 1'b1;
            if (i_return_req) begin
              if (!w_stack_empty) begin
                w_load_enable = 1'b1;
                w_load_value  = w_top;
                w_pop         = 1'b1;
              end else begin
                w_set_underflow = 1'b1;
              end
            end else if (i_call_req) begin
              // The jump is taken even when the return address is dropped.
              w_load_enable = 1'b1;
              w_load_value  = i_jump_target;
              if (!w_stack_full) begin
                w_push = 1'b1;
              end else begin
                w_set_overflow = 1'b1;
              end
            end else if (i_jump_req) begin
              w_load_enable = 1'b1;
              w_load_value  = i_jump_target;
            end else if (i_branch_req) begin
              w_offset_enable = 1'b1;
              w_offset        = i_branch_offset;
            end
          end
        end
        default: begin
          // FLUSH bubble and HALT both hold the PC and ignore requests.
          w_offset_enable = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stack pointer and sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_sp <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_set_overflow) begin
        r_overflow <= 1'b1;
      end
      if (w_set_underflow) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Stack contents need no reset: the pointer alone defines what is valid.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_stack[w_wr_idx] <= w_ret_addr;
    end
  end

  assign o_load_enable     = w_load_enable;
  assign o_load_value      = w_load_value;
  assign o_offset_enable   = w_offset_enable;
  assign o_offset          = w_offset;
  assign o_fetch           = w_fetch;
  assign o_stack_overflow  = r_overflow;
  assign o_stack_underflow = r_underflow;
  assign o_state           = r_state;

endmodule

// File: tb/tb_pc_flow_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_flow_sequencer
//   Directed bench for pc_flow_sequencer. A small ProgramCounter model closes
//   the loop (CounterValue). Each step drives requests at the falling edge and
//   pushes the hand-computed expected outputs for that cycle into a queue; a
//   separate monitor pops and compares mid-cycle.
// -----------------------------------------------------------------------------
module tb_pc_flow_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc;
  logic        stall, br, jmp, call, ret, halt, resume;
  logic [8:0]  boff;
  logic [15:0] tgt;
  logic [15:0] o_load_value;
  logic        o_load_enable;
  logic [8:0]  o_offset;
  logic        o_offset_enable;
  logic        o_fetch;
  logic        o_ovf, o_unf;
  logic [1:0]  o_state;

  int checks = 0;
  int fails  = 0;

  localparam logic [6:0] NONE = 7'd0,  BR  = 7'd1,  JMP = 7'd2,  CALL = 7'd4;
  localparam logic [6:0] RET  = 7'd8,  STL = 7'd16, HLT = 7'd32, RES  = 7'd64;
  localparam logic [1:0] S_RUN = 2'd0, S_FLUSH = 2'd1, S_HALT = 2'd2;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic [1:0]  st;
    logic        fetch;
    logic [26:0] ctl;   // {load_en, load_val[15:0], off_en, off[8:0]}
    logic [1:0]  flg;   // {overflow, underflow}
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  pc_flow_sequencer #(.STACK_DEPTH(4), .PC_W(16), .OFF_W(9)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_counter_value   (pc),
    .i_stall           (stall),
    .i_branch_req      (br),
    .i_branch_offset   (boff),
    .i_jump_req        (jmp),
    .i_call_req        (call),
    .i_jump_target     (tgt),
    .i_return_req      (ret),
    .i_halt_req        (halt),
    .i_resume          (resume),
    .o_load_value      (o_load_value),
    .o_load_enable     (o_load_enable),
    .o_offset          (o_offset),
    .o_offset_enable   (o_offset_enable),
    .o_fetch           (o_fetch),
    .o_stack_overflow  (o_ovf),
    .o_stack_underflow (o_unf),
    .o_state           (o_state)
  );

  // ProgramCounter model following the documented load/offset/increment contract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 16'h0000;
    else if (o_load_enable) pc <= o_load_value;
    else if (o_offset_enable) pc <= pc + {{7{o_offset[8]}}, o_offset};
    else pc <= pc + 16'h0001;
  end

  // Expected control encodings.
  function automatic logic [26:0] c_inc();
    return 27'd0;
  endfunction
  function automatic logic [26:0] c_hold();
    return {1'b0, 16'h0000, 1'b1, 9'h000};
  endfunction
  function automatic logic [26:0] c_load(input logic [15:0] v);
    return {1'b1, v, 1'b0, 9'h000};
  endfunction
  function automatic logic [26:0] c_off(input logic [8:0] o);
    return {1'b0, 16'h0000, 1'b1, o};
  endfunction

  task automatic step(input string nm, input logic rst_v, input logic [6:0] req,
                      input logic [15:0] t, input logic [8:0] bo,
                      input logic [15:0] e_pc, input logic [1:0] e_st,
                      input logic e_fetch, input logic [26:0] e_ctl,
                      input logic [1:0] e_flg);
    exp_t e;
    @(negedge clk);
    rst    = rst_v;
    br     = req[0];
    jmp    = req[1];
    call   = req[2];
    ret    = req[3];
    stall  = req[4];
    halt   = req[5];
    resume = req[6];
    tgt    = t;
    boff   = bo;
    e.nm = nm; e.pc = e_pc; e.st = e_st; e.fetch = e_fetch; e.ctl = e_ctl; e.flg = e_flg;
    sb_q.push_back(e);
  endtask

  // Monitor: compares one expectation per cycle, mid-cycle after inputs settle.
  initial begin
    exp_t        e;
    logic [26:0] a_ctl;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a_ctl = {o_load_enable, o_load_value, o_offset_enable, o_offset};
        checks++;
        if ({pc, o_state, o_fetch, a_ctl, o_ovf, o_unf} !==
            {e.pc, e.st, e.fetch, e.ctl, e.flg}) begin
          fails++;
          $display("FAIL %s: got pc=%h st=%0d fetch=%b ctl=%h flg=%b, want pc=%h st=%0d fetch=%b ctl=%h flg=%b",
                   e.nm, pc, o_state, o_fetch, a_ctl, {o_ovf, o_unf},
                   e.pc, e.st, e.fetch, e.ctl, e.flg);
        end else begin
          $display("ok   %s: pc=%h st=%0d fetch=%b ctl=%h flg=%b",
                   e.nm, pc, o_state, o_fetch, a_ctl, {o_ovf, o_unf});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    {stall, br, jmp, call, ret, halt, resume} = '0;
    tgt  = 16'h0000;
    boff = 9'h000;

    // Reset: requests present but every enable forced off.
    step("reset_hold",  1, JMP,  16'h1234, 9'h0, 16'h0000, S_RUN,   0, c_inc(), 2'b00);
    // 1: idle counting
    step("idle_0",      0, NONE, 16'h0, 9'h0, 16'h0000, S_RUN, 1, c_inc(), 2'b00);
    step("idle_1",      0, NONE, 16'h0, 9'h0, 16'h0001, S_RUN, 1, c_inc(), 2'b00);
    step("idle_2",      0, NONE, 16'h0, 9'h0, 16'h0002, S_RUN, 1, c_inc(), 2'b00);
    step("idle_3",      0, NONE, 16'h0, 9'h0, 16'h0003, S_RUN, 1, c_inc(), 2'b00);
    step("idle_4",      0, NONE, 16'h0, 9'h0, 16'h0004, S_RUN, 1, c_inc(), 2'b00);
    // 2: branch -3 from 5
    step("branch_m3",   0, BR,   16'h0, 9'h1FD, 16'h0005, S_RUN, 1, c_off(9'h1FD), 2'b00);
    step("flush_br",    0, JMP,  16'h00AA, 9'h0, 16'h0002, S_FLUSH, 0, c_hold(), 2'b00);
    step("after_br",    0, NONE, 16'h0, 9'h0, 16'h0002, S_RUN, 1, c_inc(), 2'b00);
    // 3: call / return
    step("jmp_10",      0, JMP,  16'h0010, 9'h0, 16'h0003, S_RUN, 1, c_load(16'h0010), 2'b00);
    step("flush_jmp",   0, NONE, 16'h0, 9'h0, 16'h0010, S_FLUSH, 0, c_hold(), 2'b00);
    step("call_100",    0, CALL, 16'h0100, 9'h0, 16'h0010, S_RUN, 1, c_load(16'h0100), 2'b00);
    step("flush_call",  0, RET,  16'h0, 9'h0, 16'h0100, S_FLUSH, 0, c_hold(), 2'b00);
    step("after_call",  0, NONE, 16'h0, 9'h0, 16'h0100, S_RUN, 1, c_inc(), 2'b00);
    step("ret_11",      0, RET,  16'h0, 9'h0, 16'h0101, S_RUN, 1, c_load(16'h0011), 2'b00);
    step("flush_ret",   0, NONE, 16'h0, 9'h0, 16'h0011, S_FLUSH, 0, c_hold(), 2'b00);
    step("after_ret",   0, NONE, 16'h0, 9'h0, 16'h0011, S_RUN, 1, c_inc(), 2'b00);
    // 4: five calls on a depth-4 stack, then five returns
    step("call1",       0, CALL, 16'h0200, 9'h0, 16'h0012, S_RUN, 1, c_load(16'h0200), 2'b00);
    step("flush_c1",    0, NONE, 16'h0, 9'h0, 16'h0200, S_FLUSH, 0, c_hold(), 2'b00);
    step("call2",       0, CALL, 16'h0300, 9'h0, 16'h0200, S_RUN, 1, c_load(16'h0300), 2'b00);
    step("flush_c2",    0, NONE, 16'h0, 9'h0, 16'h0300, S_FLUSH, 0, c_hold(), 2'b00);
    step("call3",       0, CALL, 16'h0400, 9'h0, 16'h0300, S_RUN, 1, c_load(16'h0400), 2'b00);
    step("flush_c3",    0, NONE, 16'h0, 9'h0, 16'h0400, S_FLUSH, 0, c_hold(), 2'b00);
    step("call4",       0, CALL, 16'h0500, 9'h0, 16'h0400, S_RUN, 1, c_load(16'h0500), 2'b00);
    step("flush_c4",    0, NONE, 16'h0, 9'h0, 16'h0500, S_FLUSH, 0, c_hold(), 2'b00);
    step("call5_full",  0, CALL, 16'h0600, 9'h0, 16'h0500, S_RUN, 1, c_load(16'h0600), 2'b00);
    step("flush_c5",    0, NONE, 16'h0, 9'h0, 16'h0600, S_FLUSH, 0, c_hold(), 2'b10);
    step("ret1",        0, RET,  16'h0, 9'h0, 16'h0600, S_RUN, 1, c_load(16'h0401), 2'b10);
    step("flush_r1",    0, NONE, 16'h0, 9'h0, 16'h0401, S_FLUSH, 0, c_hold(), 2'b10);
    step("ret2",        0, RET,  16'h0, 9'h0, 16'h0401, S_RUN, 1, c_load(16'h0301), 2'b10);
    step("flush_r2",    0, NONE, 16'h0, 9'h0, 16'h0301, S_FLUSH, 0, c_hold(), 2'b10);
    step("ret3",        0, RET,  16'h0, 9'h0, 16'h0301, S_RUN, 1, c_load(16'h0201), 2'b10);
    step("flush_r3",    0, NONE, 16'h0, 9'h0, 16'h0201, S_FLUSH, 0, c_hold(), 2'b10);
    step("ret4",        0, RET,  16'h0, 9'h0, 16'h0201, S_RUN, 1, c_load(16'h0013), 2'b10);
    step("flush_r4",    0, NONE, 16'h0, 9'h0, 16'h0013, S_FLUSH, 0, c_hold(), 2'b10);
    step("ret5_empty",  0, RET,  16'h0, 9'h0, 16'h0013, S_RUN, 1, c_inc(), 2'b10);
    // 5: stall beats jump, halt / resume
    step("jmp_7",       0, JMP,  16'h0007, 9'h0, 16'h0014, S_RUN, 1, c_load(16'h0007), 2'b11);
    step("flush_j7",    0, NONE, 16'h0, 9'h0, 16'h0007, S_FLUSH, 0, c_hold(), 2'b11);
    step("stall_jmp",   0, STL | JMP, 16'h0AAA, 9'h0, 16'h0007, S_RUN, 0, c_hold(), 2'b11);
    step("halt_req",    0, HLT | JMP, 16'h0AAA, 9'h0, 16'h0007, S_RUN, 0, c_hold(), 2'b11);
    step("halt_a",      0, JMP,  16'h0BBB, 9'h0, 16'h0007, S_HALT, 0, c_hold(), 2'b11);
    step("halt_b",      0, CALL, 16'h0CCC, 9'h0, 16'h0007, S_HALT, 0, c_hold(), 2'b11);
    step("halt_c",      0, BR,   16'h0, 9'h005, 16'h0007, S_HALT, 0, c_hold(), 2'b11);
    step("resume",      0, RES,  16'h0, 9'h0, 16'h0007, S_HALT, 0, c_hold(), 2'b11);
    step("after_res",   0, NONE, 16'h0, 9'h0, 16'h0007, S_RUN, 1, c_inc(), 2'b11);
    // 6: async reset in FLUSH with two stacked entries
    step("call_800",    0, CALL, 16'h0800, 9'h0, 16'h0008, S_RUN, 1, c_load(16'h0800), 2'b11);
    step("flush_800",   0, NONE, 16'h0, 9'h0, 16'h0800, S_FLUSH, 0, c_hold(), 2'b11);
    step("call_900",    0, CALL, 16'h0900, 9'h0, 16'h0800, S_RUN, 1, c_load(16'h0900), 2'b11);
    step("async_rst",   1, NONE, 16'h0, 9'h0, 16'h0000, S_RUN, 0, c_inc(), 2'b00);
    step("rst_release", 0, NONE, 16'h0, 9'h0, 16'h0000, S_RUN, 1, c_inc(), 2'b00);
    step("ret_after_rst", 0, RET, 16'h0, 9'h0, 16'h0001, S_RUN, 1, c_inc(), 2'b00);
    // Return-address wrap at the top of the address space
    step("jmp_ffff",    0, JMP,  16'hFFFF, 9'h0, 16'h0002, S_RUN, 1, c_load(16'hFFFF), 2'b01);
    step("flush_ffff",  0, NONE, 16'h0, 9'h0, 16'hFFFF, S_FLUSH, 0, c_hold(), 2'b01);
    step("call_wrap",   0, CALL, 16'h0020, 9'h0, 16'hFFFF, S_RUN, 1, c_load(16'h0020), 2'b01);
    step("flush_wrap",  0, NONE, 16'h0, 9'h0, 16'h0020, S_FLUSH, 0, c_hold(), 2'b01);
    step("ret_wrap",    0, RET,  16'h0, 9'h0, 16'h0020, S_RUN, 1, c_load(16'h0000), 2'b01);
    step("flush_rwrap", 0, NONE, 16'h0, 9'h0, 16'h0000, S_FLUSH, 0, c_hold(), 2'b01);
    step("final_idle",  0, NONE, 16'h0, 9'h0, 16'h0000, S_RUN, 1, c_inc(), 2'b01);

    // Let the monitor drain the last expectation, bounded.
    repeat (3) begin
      if (sb_q.size() > 0) @(negedge clk);
    end
    @(negedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
